// File: rtl/sdp_ram_pkg.sv
// Shared types and helpers for the byte-enable simple-dual-port RAM family.
package sdp_ram_pkg;

  typedef enum logic {
    READ_FIRST,
    WRITE_FIRST
  } collision_e;

  localparam int unsigned MaxDataBits = 1024;
  localparam int unsigned MaxLanes    = 128;

  // Lane-wise select: lanes with be set take new_word, others keep old_word.
  // Callers zero-extend to the max widths and truncate the result back.
  function automatic logic [MaxDataBits-1:0] byte_merge(
    input logic [MaxDataBits-1:0] old_word,
    input logic [MaxDataBits-1:0] new_word,
    input logic [MaxLanes-1:0]    be,
    input int unsigned            lane_bits
  );
    logic [MaxDataBits-1:0] lane_ones;
    logic [MaxDataBits-1:0] mask;
    logic [MaxLanes-1:0]    be_sh;
    lane_ones = (MaxDataBits'(1) << lane_bits) - MaxDataBits'(1);
    mask      = '0;
    be_sh     = be;
    for (int i = 0; i < MaxLanes; i++) begin
      if (be_sh[0]) begin
        mask = mask | (lane_ones << (i * lane_bits));
      end
      be_sh = be_sh >> 1;
    end
    return (new_word & mask) | (old_word & ~mask);
  endfunction

endpackage

// File: rtl/sdp_be_ram_pipe_if.sv
// Write/read port bundle for sdp_be_ram_pipe.
interface sdp_be_ram_pipe_if #(
  parameter int unsigned WDBITS    = 32,
  parameter int unsigned BYTEWIDTH = 8,
  parameter int unsigned NBYTES    = WDBITS / BYTEWIDTH,
  parameter int unsigned ABITS     = 10
);
  logic              we;
  logic [NBYTES-1:0] be;
  logic [ABITS-1:0]  wa;
  logic [WDBITS-1:0] wd;
  logic              re;
  logic [ABITS-1:0]  ra;
  logic [WDBITS-1:0] rd;
  logic              rd_valid;

  modport master (
    output we, be, wa, wd, re, ra,
    input  rd, rd_valid
  );

  modport slave (
    input  we, be, wa, wd, re, ra,
    output rd, rd_valid
  );
endinterface

// File: rtl/sdp_rd_pipe.sv
// Read data/valid register chain: stage 1 always, stage 2 when OUTREG is set.
module sdp_rd_pipe #(
  parameter int unsigned WDBITS = 32,
  parameter int unsigned OUTREG = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [WDBITS-1:0] din,
  output logic [WDBITS-1:0] dout,
  output logic              dout_valid
);

  logic [WDBITS-1:0] s1_q;
  logic              v1_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= '0;
      v1_q <= 1'b0;
    end else begin
      v1_q <= load;
      if (load) begin
        s1_q <= din;
      end
    end
  end

  if (OUTREG != 0) begin : g_outreg
    logic [WDBITS-1:0] s2_q;
    logic              v2_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        s2_q <= '0;
        v2_q <= 1'b0;
      end else begin
        v2_q <= v1_q;
        if (v1_q) begin
          s2_q <= s1_q;
        end
      end
    end

    assign dout       = s2_q;
    assign dout_valid = v2_q;
  end else begin : g_direct
    assign dout       = s1_q;
    assign dout_valid = v1_q;
  end

endmodule

// File: rtl/sdp_be_ram_pipe.sv
// Simple-dual-port block RAM with byte enables, read enable, selectable
// collision behaviour and an optional output register.
module sdp_be_ram_pipe
  import sdp_ram_pkg::*;
#(
  parameter int unsigned WDBITS    = 32,
  parameter int unsigned BYTEWIDTH = 8,
  parameter int unsigned NBYTES    = WDBITS / BYTEWIDTH,
  parameter int unsigned DEPTH     = 1024,
  parameter int unsigned ABITS     = $clog2(DEPTH),
  parameter int unsigned OUTREG    = 0,
  parameter collision_e  COLLISION = READ_FIRST
) (
  input logic               clk,
  input logic               rst,
  sdp_be_ram_pipe_if.slave  bus
);

  localparam logic [ABITS:0] DepthL = (ABITS + 1)'(DEPTH);

  (* syn_ramstyle = "block_ram" *) logic [WDBITS-1:0] mem [DEPTH];

  logic              wa_ok;
  logic              ra_ok;
  logic              wr_hit;
  logic [WDBITS-1:0] rdata;

  // Extra MSB keeps the compare correct when DEPTH is a power of two.
  assign wa_ok  = {1'b0, bus.wa} < DepthL;
  assign ra_ok  = {1'b0, bus.ra} < DepthL;
  assign wr_hit = bus.we && wa_ok && (bus.wa == bus.ra);

  // Storage has no reset so it maps onto plain block RAM.
  always_ff @(posedge clk) begin
    if (!rst && bus.we && wa_ok) begin
      for (int i = 0; i < NBYTES; i++) begin
        if (bus.be[i]) begin
          mem[bus.wa][i*BYTEWIDTH +: BYTEWIDTH] <= bus.wd[i*BYTEWIDTH +: BYTEWIDTH];
        end
      end
    end
  end

  always_comb begin
    rdata = '0;
    if (ra_ok) begin
      rdata = mem[bus.ra];
      if (COLLISION == WRITE_FIRST && wr_hit) begin
        rdata = WDBITS'(byte_merge(MaxDataBits'(mem[bus.ra]), MaxDataBits'(bus.wd),
                                   MaxLanes'(bus.be), BYTEWIDTH));
      end
    end
  end

  sdp_rd_pipe #(
    .WDBITS (WDBITS),
    .OUTREG (OUTREG)
  ) u_rd_pipe (
    .clk        (clk),
    .rst        (rst),
    .load       (bus.re),
    .din        (rdata),
    .dout       (bus.rd),
    .dout_valid (bus.rd_valid)
  );

endmodule

// File: tb/tb_sdp_be_ram_pipe.sv
// Bench: two DUTs share stimulus (A: READ_FIRST, latency 1; B: WRITE_FIRST, latency 2).
module tb_sdp_be_ram_pipe;
  import sdp_ram_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sdp_be_ram_pipe_if #(.WDBITS(32), .BYTEWIDTH(8), .NBYTES(4), .ABITS(10)) ifa ();
  sdp_be_ram_pipe_if #(.WDBITS(32), .BYTEWIDTH(8), .NBYTES(4), .ABITS(10)) ifb ();

  sdp_be_ram_pipe #(
    .WDBITS(32), .BYTEWIDTH(8), .NBYTES(4), .DEPTH(1000), .ABITS(10),
    .OUTREG(0), .COLLISION(READ_FIRST)
  ) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa.slave)
  );

  sdp_be_ram_pipe #(
    .WDBITS(32), .BYTEWIDTH(8), .NBYTES(4), .DEPTH(1000), .ABITS(10),
    .OUTREG(1), .COLLISION(WRITE_FIRST)
  ) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb.slave)
  );

  int total = 0;
  int bad   = 0;

  // Reference: stored words for addresses 0..15 plus the most recent read each port shows.
  logic [31:0] mem_m [16];
  logic [31:0] last_a, last_b, wf_prev, exp_rda, exp_rdb;
  logic        re_prev, exp_va, exp_vb;

  function automatic logic [31:0] lane_mix(input logic [31:0] old_w, input logic [31:0] new_w,
                                           input logic [3:0] be);
    logic [31:0] m;
    m = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    return (new_w & m) | (old_w & ~m);
  endfunction

  function automatic logic [31:0] model_read(input logic [9:0] a);
    if (a >= 10'd1000) return 32'h0;
    return mem_m[a[3:0]];
  endfunction

  function automatic logic [9:0] pick_addr();
    if ($urandom_range(0, 7) == 0) return 10'(1000 + $urandom_range(0, 23));
    return 10'($urandom_range(0, 15));
  endfunction

  task automatic model_reset();
    last_a  = '0; last_b  = '0; wf_prev = '0; re_prev = 1'b0;
    exp_rda = '0; exp_rdb = '0; exp_va  = 1'b0; exp_vb = 1'b0;
  endtask

  task automatic set_inputs(input logic we, input logic [3:0] be, input logic [9:0] wa,
                            input logic [31:0] wd, input logic re, input logic [9:0] ra);
    ifa.we = we; ifa.be = be; ifa.wa = wa; ifa.wd = wd; ifa.re = re; ifa.ra = ra;
    ifb.we = we; ifb.be = be; ifb.wa = wa; ifb.wd = wd; ifb.re = re; ifb.ra = ra;
  endtask

  // One clock: present inputs, advance the reference at the edge, return #1 after it.
  task automatic drive(input logic we, input logic [3:0] be, input logic [9:0] wa,
                       input logic [31:0] wd, input logic re, input logic [9:0] ra);
    logic [31:0] old_w, wf;
    @(negedge clk);
    set_inputs(we, be, wa, wd, re, ra);
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      old_w = model_read(ra);
      wf    = (we && wa < 10'd1000 && wa == ra) ? lane_mix(old_w, wd, be) : old_w;
      exp_va = re;
      if (re) last_a = old_w;
      exp_rda = last_a;
      exp_vb  = re_prev;
      if (re_prev) last_b = wf_prev;
      exp_rdb = last_b;
      re_prev = re;
      wf_prev = wf;
      if (we && wa < 10'd1000) mem_m[wa[3:0]] = lane_mix(mem_m[wa[3:0]], wd, be);
    end
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 4'h0, 10'd0, 32'h0, 1'b0, 10'd0);
  endtask

  task automatic test_reset();
    set_inputs(1'b0, 4'h0, 10'd0, 32'h0, 1'b0, 10'd0);
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (ifa.rd !== 32'h0 || ifa.rd_valid !== 1'b0) begin
      bad++; $display("FAIL reset_a: rd=%h v=%b expected rd=0 v=0", ifa.rd, ifa.rd_valid);
    end
    total++;
    if (ifb.rd !== 32'h0 || ifb.rd_valid !== 1'b0) begin
      bad++; $display("FAIL reset_b: rd=%h v=%b expected rd=0 v=0", ifb.rd, ifb.rd_valid);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [31:0] d;
    for (int a = 0; a < 16; a++) begin
      d = (a == 7) ? 32'h0 : (a == 3) ? 32'h11223344 : $urandom;
      drive(1'b1, 4'hF, 10'(a), d, 1'b0, 10'd0);
    end
    drive(1'b1, 4'hF, 10'd5, 32'hDEADBEEF, 1'b0, 10'd0);
    drive(1'b0, 4'h0, 10'd0, 32'h0, 1'b1, 10'd5);
    total++;
    if (ifa.rd !== 32'hDEADBEEF || ifa.rd_valid !== 1'b1) begin
      bad++; $display("FAIL basic_a: rd=%h v=%b expected rd=deadbeef v=1", ifa.rd, ifa.rd_valid);
    end
    total++;
    if (ifb.rd_valid !== 1'b0) begin
      bad++; $display("FAIL basic_b_early: v=%b expected v=0", ifb.rd_valid);
    end
    idle();
    total++;
    if (ifb.rd !== 32'hDEADBEEF || ifb.rd_valid !== 1'b1) begin
      bad++; $display("FAIL basic_b: rd=%h v=%b expected rd=deadbeef v=1", ifb.rd, ifb.rd_valid);
    end
    total++;
    if (ifa.rd !== 32'hDEADBEEF || ifa.rd_valid !== 1'b0) begin
      bad++; $display("FAIL basic_a_hold: rd=%h v=%b expected rd=deadbeef v=0",
                      ifa.rd, ifa.rd_valid);
    end
  endtask

  task automatic test_byte_enables();
    drive(1'b1, 4'hF, 10'd3, 32'h11223344, 1'b0, 10'd0);
    drive(1'b1, 4'b0101, 10'd3, 32'hAABBCCDD, 1'b0, 10'd0);
    drive(1'b0, 4'h0, 10'd0, 32'h0, 1'b1, 10'd3);
    total++;
    if (ifa.rd !== 32'h11BB33DD || ifa.rd_valid !== 1'b1) begin
      bad++; $display("FAIL be_a: rd=%h v=%b expected rd=11bb33dd v=1", ifa.rd, ifa.rd_valid);
    end
    idle();
    total++;
    if (ifb.rd !== 32'h11BB33DD || ifb.rd_valid !== 1'b1) begin
      bad++; $display("FAIL be_b: rd=%h v=%b expected rd=11bb33dd v=1", ifb.rd, ifb.rd_valid);
    end
  endtask

  task automatic test_collision();
    drive(1'b1, 4'hF, 10'd7, 32'h0, 1'b0, 10'd0);
    drive(1'b1, 4'b0011, 10'd7, 32'hFFFFFFFF, 1'b1, 10'd7);
    total++;
    if (ifa.rd !== 32'h0 || ifa.rd_valid !== 1'b1) begin
      bad++; $display("FAIL coll_rf: rd=%h v=%b expected rd=00000000 v=1", ifa.rd, ifa.rd_valid);
    end
    idle();
    total++;
    if (ifb.rd !== 32'h0000FFFF || ifb.rd_valid !== 1'b1) begin
      bad++; $display("FAIL coll_wf: rd=%h v=%b expected rd=0000ffff v=1", ifb.rd, ifb.rd_valid);
    end
    drive(1'b0, 4'h0, 10'd0, 32'h0, 1'b1, 10'd7);
    total++;
    if (ifa.rd !== 32'h0000FFFF || ifa.rd_valid !== 1'b1) begin
      bad++; $display("FAIL coll_after_a: rd=%h v=%b expected rd=0000ffff v=1",
                      ifa.rd, ifa.rd_valid);
    end
    idle();
    total++;
    if (ifb.rd !== 32'h0000FFFF || ifb.rd_valid !== 1'b1) begin
      bad++; $display("FAIL coll_after_b: rd=%h v=%b expected rd=0000ffff v=1",
                      ifb.rd, ifb.rd_valid);
    end
  endtask

  task automatic test_streaming();
    for (int k = 0; k < 5; k++) begin
      if (k < 3) drive(1'b0, 4'h0, 10'd0, 32'h0, 1'b1, 10'(k));
      else idle();
      total++;
      if (ifa.rd !== exp_rda || ifa.rd_valid !== exp_va) begin
        bad++; $display("FAIL stream_a[%0d]: rd=%h v=%b expected rd=%h v=%b",
                        k, ifa.rd, ifa.rd_valid, exp_rda, exp_va);
      end
      total++;
      if (ifb.rd !== exp_rdb || ifb.rd_valid !== exp_vb) begin
        bad++; $display("FAIL stream_b[%0d]: rd=%h v=%b expected rd=%h v=%b",
                        k, ifb.rd, ifb.rd_valid, exp_rdb, exp_vb);
      end
    end
    total++;
    if (ifa.rd !== mem_m[2] || ifb.rd !== mem_m[2] || ifa.rd_valid || ifb.rd_valid) begin
      bad++; $display("FAIL stream_hold: a=%h b=%h expected %h with valid low",
                      ifa.rd, ifb.rd, mem_m[2]);
    end
  endtask

  task automatic test_out_of_range();
    drive(1'b1, 4'hF, 10'd1001, $urandom, 1'b0, 10'd0);
    drive(1'b0, 4'h0, 10'd0, 32'h0, 1'b1, 10'd1001);
    total++;
    if (ifa.rd !== 32'h0 || ifa.rd_valid !== 1'b1) begin
      bad++; $display("FAIL oor_a: rd=%h v=%b expected rd=0 v=1", ifa.rd, ifa.rd_valid);
    end
    idle();
    total++;
    if (ifb.rd !== 32'h0 || ifb.rd_valid !== 1'b1) begin
      bad++; $display("FAIL oor_b: rd=%h v=%b expected rd=0 v=1", ifb.rd, ifb.rd_valid);
    end
    for (int k = 0; k < 18; k++) begin
      if (k < 16) drive(1'b0, 4'h0, 10'd0, 32'h0, 1'b1, 10'(k));
      else idle();
      total++;
      if (ifa.rd !== exp_rda || ifa.rd_valid !== exp_va ||
          ifb.rd !== exp_rdb || ifb.rd_valid !== exp_vb) begin
        bad++; $display("FAIL oor_scan[%0d]: a=%h/%b b=%h/%b expected a=%h/%b b=%h/%b", k,
                        ifa.rd, ifa.rd_valid, ifb.rd, ifb.rd_valid,
                        exp_rda, exp_va, exp_rdb, exp_vb);
      end
    end
  endtask

  task automatic test_mid_read_reset();
    drive(1'b0, 4'h0, 10'd0, 32'h0, 1'b1, 10'd5);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    total++;
    if (ifa.rd !== 32'h0 || ifa.rd_valid !== 1'b0 || ifb.rd !== 32'h0 || ifb.rd_valid !== 1'b0)
    begin
      bad++; $display("FAIL mid_rst_async: a=%h/%b b=%h/%b expected all 0",
                      ifa.rd, ifa.rd_valid, ifb.rd, ifb.rd_valid);
    end
    drive(1'b1, 4'hF, 10'd5, $urandom, 1'b1, 10'd5);
    idle();
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      idle();
      total++;
      if (ifa.rd_valid !== 1'b0 || ifb.rd_valid !== 1'b0 || ifb.rd !== 32'h0) begin
        bad++; $display("FAIL mid_rst_quiet[%0d]: va=%b vb=%b rdb=%h expected 0/0/0",
                        k, ifa.rd_valid, ifb.rd_valid, ifb.rd);
      end
    end
    drive(1'b0, 4'h0, 10'd0, 32'h0, 1'b1, 10'd5);
    total++;
    if (ifa.rd !== 32'hDEADBEEF || ifa.rd_valid !== 1'b1) begin
      bad++; $display("FAIL mid_rst_keep_a: rd=%h v=%b expected rd=deadbeef v=1",
                      ifa.rd, ifa.rd_valid);
    end
    idle();
    total++;
    if (ifb.rd !== 32'hDEADBEEF || ifb.rd_valid !== 1'b1) begin
      bad++; $display("FAIL mid_rst_keep_b: rd=%h v=%b expected rd=deadbeef v=1",
                      ifb.rd, ifb.rd_valid);
    end
  endtask

  task automatic test_random();
    logic       we, re;
    logic [3:0] be;
    logic [9:0] wa, ra;
    for (int k = 0; k < 400; k++) begin
      we = 1'($urandom_range(0, 1));
      re = ($urandom_range(0, 3) != 0);
      be = 4'($urandom);
      wa = pick_addr();
      ra = ($urandom_range(0, 3) == 0) ? wa : pick_addr();
      drive(we, be, wa, $urandom, re, ra);
      total++;
      if (ifa.rd !== exp_rda || ifa.rd_valid !== exp_va) begin
        bad++; $display("FAIL rand_a[%0d]: rd=%h v=%b expected rd=%h v=%b",
                        k, ifa.rd, ifa.rd_valid, exp_rda, exp_va);
      end
      total++;
      if (ifb.rd !== exp_rdb || ifb.rd_valid !== exp_vb) begin
        bad++; $display("FAIL rand_b[%0d]: rd=%h v=%b expected rd=%h v=%b",
                        k, ifb.rd, ifb.rd_valid, exp_rdb, exp_vb);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_byte_enables();
    test_collision();
    test_streaming();
    test_out_of_range();
    test_mid_read_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sdp_be_ram_pipe.md
# sdp_be_ram_pipe

Parametrised simple-dual-port block RAM with per-byte write enables: one write port, one read port, one clock. It generalises the byte-enable SDP memory with a read enable, selectable read/write collision mode, an optional output pipeline register and a read-valid flag. It sits in the BRAM inference test suite as the next-generation mapping target (`syn_ramstyle = "block_ram"` on the storage array).

## Interface
- `WDBITS`, 32: data width, identical on the read and write ports; must be a multiple of `BYTEWIDTH`.
- `BYTEWIDTH`, 8: lane width, 8 or 9.
- `NBYTES`, `WDBITS/BYTEWIDTH`: number of byte-enable lanes (derived).
- `DEPTH`, 1024: number of words; need not be a power of two.
- `ABITS`, `$clog2(DEPTH)`: address width for both ports.
- `OUTREG`, 0: 0 gives 1-cycle read latency; 1 adds an output register for 2-cycle latency.
- `COLLISION`, `READ_FIRST`: same-address same-cycle behaviour, `READ_FIRST` or `WRITE_FIRST`.
- `clk`, input, 1: single clock; all logic on the rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `we`, input, 1: write request.
- `be`, input, `NBYTES`: byte lane enables, qualified by `we`.
- `wa`, input, `ABITS`: write address.
- `wd`, input, `WDBITS`: write data; lane i is `wd[i*BYTEWIDTH +: BYTEWIDTH]`.
- `re`, input, 1: read request.
- `ra`, input, `ABITS`: read address.
- `rd`, output, `WDBITS`: registered read data.
- `rd_valid`, output, 1: high in the cycle `rd` carries data for an accepted read.

## Operation
- Write: on a rising edge with `we=1`, `rst=0` and `wa<DEPTH`, each lane i with `be[i]=1` is overwritten. Other lanes are unchanged. `we=1, be=0` is a no-op.
- Read: on a rising edge with `re=1` and `rst=0`, the word at `ra` is captured into stage 1.
  - If `ra>=DEPTH`, stage 1 captures all-zero data.
  - With `re=0`, stage 1 holds its value.
- Collision: when `re`, `we`, `ra==wa` and the address is in range:
  - `READ_FIRST`: `rd` returns the old word.
  - `WRITE_FIRST`: each lane with `be[i]=1` returns `wd` for that lane; other lanes return the old contents.
- Valid tracking: `rd_valid` follows `re` through the same number of stages as the data. A hold cycle (`re=0`) deasserts `rd_valid` but leaves `rd` unchanged.
- `OUTREG=1`: stage 2 loads from stage 1 every cycle that stage 1 holds valid data. Otherwise stage 2 holds.
- Reset:
  - Clears `rd`, `rd_valid` and all internal stage registers to 0.
  - Memory contents are not reset.
  - Writes and reads presented while `rst=1` are ignored.
  - A read in flight when `rst` asserts is discarded; no `rd_valid` follows it.

## Timing
- Read latency is 1 (`OUTREG=0`) or 2 (`OUTREG=1`) rising edges, from the `re` edge to `rd`/`rd_valid`.
- Back-to-back reads every cycle give full throughput: one word per clock.
- A write at edge N is visible to a read accepted at edge N+1 in both modes.
- At edge N itself, the collision mode decides what a same-address read returns.
- `rst` asserting asynchronously forces `rd=0` and `rd_valid=0` immediately.
- The first edge after `rst` deasserts may accept a read or write.

## Structure
- Package `sdp_ram_pkg`:
  - enum `collision_e` with values `READ_FIRST` and `WRITE_FIRST`.
  - function `byte_merge(old, new, be)`, returning a lane-wise select. It is reused by the `WRITE_FIRST` bypass.
- Sub-module `sdp_rd_pipe`: the data/valid output register chain (stage 1 and optional stage 2, async reset), parametrised by `WDBITS` and `OUTREG`.
- The storage array and write logic stay in the top level, so BRAM inference sees a plain memory.

## Test plan
- Reset and initial state:
  - With `rst=1`, `rd=0` and `rd_valid=0`.
  - After release: write `wa=5`, `wd=32'hDEADBEEF`, `be=4'hF`; then read `ra=5`.
  - Expect `rd=32'hDEADBEEF` with `rd_valid=1`, 1 cycle later (`OUTREG=0`) or 2 cycles later (`OUTREG=1`).
- Byte enables:
  - Fill address 3 with `32'h11223344`, then write `wd=32'hAABBCCDD` with `be=4'b0101`.
  - Reading address 3 returns `32'h11BB33DD`.
- Collision:
  - Address 7 holds `32'h0`. In one cycle, write `32'hFFFFFFFF` with `be=4'b0011` and read the same address.
  - `READ_FIRST` returns `32'h00000000`; `WRITE_FIRST` returns `32'h0000FFFF`.
  - The next read of address 7 returns `32'h0000FFFF` in both modes.
- Hold and streaming:
  - Read addresses 0, 1, 2 on consecutive cycles, then `re=0`.
  - Three consecutive `rd_valid` pulses with the correct words; `rd` then holds the word from address 2 while `rd_valid=0`.
- Out-of-range access, `DEPTH=1000`:
  - A write to `wa=1001` changes no stored word.
  - A read of `ra=1001` returns 0 with `rd_valid=1`.
- Mid-read reset, `OUTREG=1`:
  - Assert `rst` one cycle after `re`.
  - `rd` and `rd_valid` drop to 0 at once; no `rd_valid` appears after release.
  - Earlier written contents are still readable after release.
